// File: rtl/down_timer.sv
// down_timer: loadable down counter with reload register, programmable prescaler,
// and one-shot or periodic terminal-count generation.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | not counting; COUNT held (resume point for START)
//   RUN     | counting; prescaler advances while ENABLE is high
//   EXPIRED | one-shot reached terminal count; COUNT held at 0
module down_timer #(
    parameter int WIDTH     = 8,
    parameter int PSC_WIDTH = 8
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic                 LOAD,
    input  logic [WIDTH-1:0]     DATA,
    input  logic                 START,
    input  logic                 STOP,
    input  logic                 PERIODIC,
    input  logic [PSC_WIDTH-1:0] PRESCALE,
    output logic [WIDTH-1:0]     COUNT,
    output logic                 TC,
    output logic                 RUNNING,
    output logic                 DONE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     count_q, count_nxt;
    logic [WIDTH-1:0]     reload_q, reload_nxt;
    logic [PSC_WIDTH-1:0] psc_q, psc_nxt;
    logic                 mode_q, mode_nxt;
    logic                 tc_q, tc_nxt;
    logic                 running_q, done_q;
    logic                 tick;

    // >= rather than == so a lowered PRESCALE takes effect without wrapping
    assign tick = (state == RUN) && ENABLE && (psc_q >= PRESCALE);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            psc_q     <= '0;
            mode_q    <= 1'b0;
            tc_q      <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            count_q   <= count_nxt;
            reload_q  <= reload_nxt;
            psc_q     <= psc_nxt;
            mode_q    <= mode_nxt;
            tc_q      <= tc_nxt;
            running_q <= (state_nxt == RUN);
            done_q    <= (state_nxt == EXPIRED);
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count_q;
        reload_nxt = reload_q;
        psc_nxt    = psc_q;
        mode_nxt   = mode_q;
        tc_nxt     = 1'b0;

        if (state != IDLE && state != RUN && state != EXPIRED) begin
            state_nxt = IDLE;
            psc_nxt   = '0;
        end else if (LOAD) begin
            count_nxt  = DATA;
            reload_nxt = DATA;
            psc_nxt    = '0;
            if (START && state != RUN) begin
                state_nxt = RUN;
                mode_nxt  = PERIODIC;
            end else if (state == EXPIRED) begin
                state_nxt = IDLE;
            end
        end else if (STOP) begin
            state_nxt = IDLE;
            psc_nxt   = '0;
        end else if (START && state != RUN) begin
            state_nxt = RUN;
            mode_nxt  = PERIODIC;
            psc_nxt   = '0;
            if (state == EXPIRED) begin
                count_nxt = reload_q;
            end
        end else if (tick) begin
            psc_nxt = '0;
            if (count_q != '0) begin
                count_nxt = count_q - 1'b1;
            end else begin
                tc_nxt = 1'b1;
                if (mode_q) begin
                    count_nxt = reload_q;
                end else begin
                    state_nxt = EXPIRED;
                end
            end
        end else if (state == RUN && ENABLE) begin
            psc_nxt = psc_q + 1'b1;
        end
    end

    assign COUNT   = count_q;
    assign TC      = tc_q;
    assign RUNNING = running_q;
    assign DONE    = done_q;

endmodule
